div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- DivMMC paging controller: the producer side of the `divMap`/`divRam`/`divPage` interface that the memory mapper consumes.
- Snoops Z80 bus cycles and holds the control register at I/O port 0xE3 (CONMEM, MAPRAM, bank).
- Runs the automap state machine: delayed map on ROM entry-point fetches, instant map on 0x3Dxx, delayed unmap on 0x1FF8–0x1FFF.
- Sits beside the CPU and drives the memory mapper's divMMC inputs directly.

Parameters:
- PORT, 8'hE3, I/O address decoded on a[7:0].
- MAPRAM_LOCK, 1: 1 = MAPRAM is write-once (set only, cleared only by reset); 0 = freely writable.

Ports:
- clock  in  1  CPU clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- mreq  in  1  Z80 MREQ, active-low.
- iorq  in  1  Z80 IORQ, active-low.
- m1  in  1  Z80 M1, active-low.
- rd  in  1  Z80 RD, active-low.
- wr  in  1  Z80 WR, active-low.
- a  in  16  CPU address.
- di  in  8  CPU data out (for port writes).
- divMap  out  1  divMMC memory paged into 0x0000–0x3FFF.
- divRam  out  1  0x0000–0x1FFF comes from RAM bank 3 instead of divMMC ROM.
- divPage  out  4  RAM bank mapped at 0x2000–0x3FFF.

Behaviour:
- Reset (reset=0, async): conmem=0, mapram=0, bank=0, automap=0, mapPend=0, unmapPend=0.
  - Outputs: divMap=0, divRam=0, divPage=0.
  - Reset mid-fetch discards any pending map/unmap.
- Port write:
  - Detected at a rising edge with iorq=0, wr=0, m1=1, a[7:0]==PORT.
  - conmem<=di[7]; bank<=di[3:0].
  - mapram: MAPRAM_LOCK=1 gives mapram<=mapram|di[6]; MAPRAM_LOCK=0 gives mapram<=di[6].
  - Held for the whole IORQ cycle; re-latching the same value is harmless.
  - Port reads: no response (write-only).
- Fetch qualifier fetch = !m1 && !mreq && !rd, sampled each rising edge. Interrupt-ack (m1=0, iorq=0) is not a fetch and is ignored.
- Automap state machine, states IDLE, PEND_MAP, PEND_UNMAP:
  - IDLE: fetch with a in {0x0000, 0x0008, 0x0038, 0x0066, 0x04C6, 0x0562} or a[15:8]==0x3D → PEND_MAP. Fetch with a in 0x1FF8–0x1FFF → PEND_UNMAP.
  - PEND_*: wait for m1 sampled high. Then automap<=1 (PEND_MAP) or automap<=0 (PEND_UNMAP), and return to IDLE.
  - Resulting latency: the registered divMap change is visible 1 clock after m1 is first sampled high, so it never alters the opcode byte currently being fetched.
  - A fetch at an entry point while automap=1 still passes through PEND_MAP; the output does not change.
- Instant map: divMap is asserted combinationally while fetch && a[15:8]==0x3D, so that fetch already reads divMMC ROM. The register then latches through PEND_MAP.
- Output equations:
  - divMap = conmem | automap | instant.
  - divRam = mapram & !conmem (CONMEM forces ROM at 0x0000–0x1FFF).
  - divPage = bank.
- Simultaneous events: port write and state-machine transition in the same clock are independent. An unmap clears only automap; conmem=1 keeps divMap=1.
- Write protection of bank 3 when MAPRAM is set is not handled here; it belongs to the memory block.

Optional Feature:
- Macro: DIV_NMI_EN.
- Defined:
  - Adds ports `nmiButton` (in, 1, active-high, synchronised internally with 2 flops) and `nmi` (out, 1, active-low).
  - A synchronised rising edge of the button sets nmiReq; nmi = !nmiReq.
  - nmiReq clears when the automap state machine leaves PEND_MAP for a fetch at 0x0066.
  - Reset clears nmiReq.
- Undefined: these ports and that logic are absent.

Decomposition:
- Shared package div_pkg holds:
  - the entry-point address constants;
  - the unmap range base 16'h1FF8 and mask;
  - the instant page 8'h3D;
  - the port-register bit positions (CONMEM=7, MAPRAM=6, BANK=3:0);
  - the state encoding for IDLE, PEND_MAP, PEND_UNMAP.
- One sub-module, div_automap: fetch decode, pending state machine, automap flag and instant term. div_ctrl keeps the port register and output equations.

Test Plan:
- Reset, then OUT (0xE3),0x85 → divMap=1, divRam=0, divPage=5. Then OUT 0x00 → divMap=0.
- Fetch at 0x0038 → divMap stays 0 during the fetch, and becomes 1 one clock after m1 goes high. Next fetch at 0x1FFA → divMap drops 1 clock after that M1 ends.
- Fetch at 0x3D2F → divMap=1 combinationally in the same cycle and stays 1 after M1 ends.
- OUT 0x40, then OUT 0x00 with MAPRAM_LOCK=1 → divRam stays 1. OUT 0x80 → divRam=0 while conmem=1.
- Interrupt ack (m1=0, iorq=0, a=0x0038) → no automap. Assert reset while in PEND_MAP → after release, divMap=0 and no map occurs.
- DIV_NMI_EN defined: pulse nmiButton → nmi=0 within 3 clocks. Fetch 0x0066 then M1 end → nmi=1 and divMap=1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants and types for the DivMMC paging controller: automap entry points,
// unmap window, control-register bit layout and automap state encoding.
package div_pkg;

   localparam logic [15:0] ENTRY_RST00     = 16'h0000;
   localparam logic [15:0] ENTRY_RST08     = 16'h0008;
   localparam logic [15:0] ENTRY_RST38     = 16'h0038;
   localparam logic [15:0] ENTRY_NMI       = 16'h0066;
   localparam logic [15:0] ENTRY_TAPE_LOAD = 16'h04C6;
   localparam logic [15:0] ENTRY_TAPE_SAVE = 16'h0562;

   localparam logic [15:0] UNMAP_BASE   = 16'h1FF8;
   localparam logic [15:0] UNMAP_MASK   = 16'hFFF8;
   localparam logic [7:0]  INSTANT_PAGE = 8'h3D;

   localparam int CONMEM_BIT = 7;
   localparam int MAPRAM_BIT = 6;
   localparam int BANK_MSB   = 3;
   localparam int BANK_LSB   = 0;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PEND_MAP   = 2'd1,
      PEND_UNMAP = 2'd2
   } autoState_t;

   function automatic logic isEntryPoint(input logic [15:0] addr);
      return addr inside {ENTRY_RST00, ENTRY_RST08, ENTRY_RST38,
                          ENTRY_NMI, ENTRY_TAPE_LOAD, ENTRY_TAPE_SAVE};
   endfunction

   function automatic logic inUnmapRange(input logic [15:0] addr);
      return (addr & UNMAP_MASK) == UNMAP_BASE;
   endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Z80 bus snoop signals plus the divMap/divRam/divPage outputs consumed by the memory mapper.
interface div_ctrl_if;

   logic        mreq;
   logic        iorq;
   logic        m1;
   logic        rd;
   logic        wr;
   logic [15:0] a;
   logic [7:0]  di;
   logic        divMap;
   logic        divRam;
   logic [3:0]  divPage;

   modport master (
      output mreq, iorq, m1, rd, wr, a, di,
      input  divMap, divRam, divPage
   );

   modport slave (
      input  mreq, iorq, m1, rd, wr, a, di,
      output divMap, divRam, divPage
   );

endinterface

// File: rtl/div_automap.sv
// Automap engine: decodes opcode fetches, holds the pending map/unmap state and the
// registered automap flag, and produces the combinational instant-map term for 0x3Dxx.
module div_automap
   import div_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        m1,
   input  logic        mreq,
   input  logic        rd,
   input  logic [15:0] a,
   output logic        automap,
   output logic        instant
`ifdef DIV_NMI_EN
   ,
   output logic        nmiAck
`endif
);

   autoState_t state;
   logic       fetch;
   logic       instantPage;
   logic       mapHit;
   logic       unmapHit;

   // Interrupt acknowledge keeps RD high, so it never qualifies as a fetch.
   assign fetch       = !m1 && !mreq && !rd;
   assign instantPage = (a[15:8] == INSTANT_PAGE);
   assign instant     = fetch && instantPage;
   assign mapHit      = isEntryPoint(a) || instantPage;
   assign unmapHit    = inUnmapRange(a);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         automap <= 1'b0;
      end else begin
         // NOTE: non-blocking updates keep state and automap consistent within the same edge.
         case (state)
            IDLE: begin
               if (fetch && mapHit)        state <= PEND_MAP;
               else if (fetch && unmapHit) state <= PEND_UNMAP;
            end
            PEND_MAP: begin
               if (m1) begin
                  automap <= 1'b1;
                  state   <= IDLE;
               end
            end
            PEND_UNMAP: begin
               if (m1) begin
                  automap <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DIV_NMI_EN
   logic nmiPend;

   // Remembers whether the pending map came from the NMI entry point.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                                  nmiPend <= 1'b0;
      else if (state == IDLE && fetch && mapHit)   nmiPend <= (a == ENTRY_NMI);
   end

   assign nmiAck = (state == PEND_MAP) && m1 && nmiPend;
`endif

endmodule

// File: rtl/div_ctrl.sv
// DivMMC paging controller: port 0xE3 control register, output equations and automap.
// Optional DIV_NMI_EN adds a synchronised NMI button input and an active-low nmi output.
module div_ctrl
   import div_pkg::*;
#(
   parameter logic [7:0] PORT        = 8'hE3,
   parameter bit         MAPRAM_LOCK = 1'b1
)
(
   input  logic       clock,
   input  logic       reset,
   div_ctrl_if.slave  bus
`ifdef DIV_NMI_EN
   ,
   input  logic       nmiButton,
   output logic       nmi
`endif
);

   logic       conmem;
   logic       mapram;
   logic [3:0] bank;
   logic       automap;
   logic       instant;
   logic       portWrite;
   logic       unusedDi;

`ifdef DIV_NMI_EN
   logic       nmiAck;
`endif

   assign portWrite = !bus.iorq && !bus.wr && bus.m1 && (bus.a[7:0] == PORT);
   assign unusedDi  = ^bus.di[5:4];

   // Writes repeat on every edge of the IORQ cycle; re-latching the same value is harmless.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         conmem <= 1'b0;
         mapram <= 1'b0;
         bank   <= 4'd0;
      end else if (portWrite) begin
         conmem <= bus.di[CONMEM_BIT];
         mapram <= MAPRAM_LOCK ? (mapram | bus.di[MAPRAM_BIT]) : bus.di[MAPRAM_BIT];
         bank   <= bus.di[BANK_MSB:BANK_LSB];
      end
   end

   div_automap u_automap (
      .clock   (clock),
      .reset   (reset),
      .m1      (bus.m1),
      .mreq    (bus.mreq),
      .rd      (bus.rd),
      .a       (bus.a),
      .automap (automap),
      .instant (instant)
`ifdef DIV_NMI_EN
      ,
      .nmiAck  (nmiAck)
`endif
   );

   assign bus.divMap  = conmem | automap | instant;
   assign bus.divRam  = mapram & !conmem;
   assign bus.divPage = bank;

`ifdef DIV_NMI_EN
   logic [1:0] btnSync;
   logic       btnLast;
   logic       nmiReq;

   // A new button edge wins over a simultaneous acknowledge so no press is lost.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         btnSync <= 2'b00;
         btnLast <= 1'b0;
         nmiReq  <= 1'b0;
      end else begin
         btnSync <= {btnSync[0], nmiButton};
         btnLast <= btnSync[1];
         if (btnSync[1] && !btnLast) nmiReq <= 1'b1;
         else if (nmiAck)            nmiReq <= 1'b0;
      end
   end

   assign nmi = !nmiReq;
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed scenarios plus randomized bus traffic
// checked against a transaction-level model of the paging rules.
module tb_div_ctrl;

   logic clock = 1'b0;
   logic reset = 1'b0;

   div_ctrl_if bus();

`ifdef DIV_NMI_EN
   logic nmiButton = 1'b0;
   logic nmi;
`endif

   div_ctrl #(.PORT(8'hE3), .MAPRAM_LOCK(1'b1)) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus)
`ifdef DIV_NMI_EN
      ,
      .nmiButton (nmiButton),
      .nmi       (nmi)
`endif
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit         mConmem;
   bit         mMapram;
   bit         mAutomap;
   logic [3:0] mBank;

   function automatic bit isEntry(input logic [15:0] addr);
      logic [15:0] entries [6] = '{16'h0000, 16'h0008, 16'h0038, 16'h0066, 16'h04C6, 16'h0562};
      foreach (entries[i]) if (entries[i] == addr) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit expMap();
      return mConmem | mAutomap;
   endfunction

   function automatic bit expRam();
      return mMapram & !mConmem;
   endfunction

   task automatic modelReset();
      mConmem = 0; mMapram = 0; mAutomap = 0; mBank = 4'd0;
   endtask

   task automatic modelFetch(input logic [15:0] addr);
      if (isEntry(addr) || addr[15:8] == 8'h3D) mAutomap = 1;
      else if (addr >= 16'h1FF8 && addr <= 16'h1FFF) mAutomap = 0;
   endtask

   function automatic logic [15:0] pickAddr();
      logic [15:0] entries [6] = '{16'h0000, 16'h0008, 16'h0038, 16'h0066, 16'h04C6, 16'h0562};
      logic [15:0] near [6]    = '{16'h1FF7, 16'h2000, 16'h0039, 16'h0065, 16'h3CFF, 16'h3E00};
      case ($urandom_range(0, 4))
         0:       return entries[$urandom_range(0, 5)];
         1:       return {8'h3D, 8'($urandom)};
         2:       return 16'h1FF8 + 16'($urandom_range(0, 7));
         3:       return near[$urandom_range(0, 5)];
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic busIdle();
      bus.mreq = 1; bus.iorq = 1; bus.m1 = 1; bus.rd = 1; bus.wr = 1;
   endtask

   task automatic outPort(input logic [15:0] addr, input logic [7:0] data);
      @(negedge clock);
      bus.a = addr; bus.di = data; bus.iorq = 0; bus.wr = 0;
      repeat (2) @(negedge clock);
      busIdle();
      @(posedge clock); #1;
      if (addr[7:0] == 8'hE3) begin
         mConmem = data[7];
         mMapram = mMapram | data[6];
         mBank   = data[3:0];
      end
   endtask

   task automatic fetchStart(input logic [15:0] addr);
      @(negedge clock);
      bus.a = addr; bus.m1 = 0; bus.mreq = 0; bus.rd = 0;
      @(negedge clock);
   endtask

   task automatic fetchEnd();
      busIdle();
      #1;
   endtask

   task automatic runFetch(input logic [15:0] addr);
      fetchStart(addr);
      fetchEnd();
      @(posedge clock); #1;
      modelFetch(addr);
   endtask

   task automatic test_reset();
      busIdle(); bus.a = 16'h0000; bus.di = 8'h00;
      modelReset();
      repeat (3) @(negedge clock);
      checks++; if (bus.divMap !== 1'b0) begin errors++; $display("FAIL reset_map: got %0b expected 0", bus.divMap); end
      checks++; if (bus.divRam !== 1'b0) begin errors++; $display("FAIL reset_ram: got %0b expected 0", bus.divRam); end
      checks++; if (bus.divPage !== 4'd0) begin errors++; $display("FAIL reset_page: got %0h expected 0", bus.divPage); end
`ifdef DIV_NMI_EN
      checks++; if (nmi !== 1'b1) begin errors++; $display("FAIL reset_nmi: got %0b expected 1", nmi); end
`endif
      reset = 1;
      repeat (2) @(negedge clock);
      checks++; if (bus.divMap !== 1'b0) begin errors++; $display("FAIL post_reset_map: got %0b expected 0", bus.divMap); end
   endtask

   task automatic test_port();
      outPort(16'h00E3, 8'h85);
      checks++; if (bus.divMap !== 1'b1) begin errors++; $display("FAIL port85_map: got %0b expected 1", bus.divMap); end
      checks++; if (bus.divRam !== 1'b0) begin errors++; $display("FAIL port85_ram: got %0b expected 0", bus.divRam); end
      checks++; if (bus.divPage !== 4'd5) begin errors++; $display("FAIL port85_page: got %0h expected 5", bus.divPage); end
      outPort(16'h00E3, 8'h00);
      checks++; if (bus.divMap !== 1'b0) begin errors++; $display("FAIL port00_map: got %0b expected 0", bus.divMap); end
      checks++; if (bus.divPage !== 4'd0) begin errors++; $display("FAIL port00_page: got %0h expected 0", bus.divPage); end
      outPort(16'h00E7, 8'h8F);
      checks++; if (bus.divPage !== 4'd0) begin errors++; $display("FAIL other_port_page: got %0h expected 0", bus.divPage); end
      checks++; if (bus.divMap !== 1'b0) begin errors++; $display("FAIL other_port_map: got %0b expected 0", bus.divMap); end
   endtask

   task automatic test_automap();
      fetchStart(16'h0038);
      checks++; if (bus.divMap !== 1'b0) begin errors++; $display("FAIL map_during_fetch: got %0b expected 0", bus.divMap); end
      fetchEnd();
      checks++; if (bus.divMap !== 1'b0) begin errors++; $display("FAIL map_before_edge: got %0b expected 0", bus.divMap); end
      @(posedge clock); #1;
      modelFetch(16'h0038);
      checks++; if (bus.divMap !== 1'b1) begin errors++; $display("FAIL map_after_m1: got %0b expected 1", bus.divMap); end
      runFetch(16'h0000);
      checks++; if (bus.divMap !== 1'b1) begin errors++; $display("FAIL remap_entry: got %0b expected 1", bus.divMap); end
      fetchStart(16'h1FFA);
      checks++; if (bus.divMap !== 1'b1) begin errors++; $display("FAIL unmap_during_fetch: got %0b expected 1", bus.divMap); end
      fetchEnd();
      checks++; if (bus.divMap !== 1'b1) begin errors++; $display("FAIL unmap_before_edge: got %0b expected 1", bus.divMap); end
      @(posedge clock); #1;
      modelFetch(16'h1FFA);
      checks++; if (bus.divMap !== 1'b0) begin errors++; $display("FAIL unmap_after_m1: got %0b expected 0", bus.divMap); end
      runFetch(16'h1FF7);
      checks++; if (bus.divMap !== 1'b0) begin errors++; $display("FAIL below_unmap_window: got %0b expected 0", bus.divMap); end
   endtask

   task automatic test_instant();
      @(negedge clock);
      bus.a = 16'h3D00; bus.mreq = 0; bus.rd = 0;
      #1;
      checks++; if (bus.divMap !== 1'b0) begin errors++; $display("FAIL instant_non_m1: got %0b expected 0", bus.divMap); end
      busIdle();
      fetchStart(16'h3D2F);
      checks++; if (bus.divMap !== 1'b1) begin errors++; $display("FAIL instant_during_fetch: got %0b expected 1", bus.divMap); end
      fetchEnd();
      @(posedge clock); #1;
      modelFetch(16'h3D2F);
      checks++; if (bus.divMap !== 1'b1) begin errors++; $display("FAIL instant_latched: got %0b expected 1", bus.divMap); end
      repeat (2) @(negedge clock);
      checks++; if (bus.divMap !== 1'b1) begin errors++; $display("FAIL instant_held: got %0b expected 1", bus.divMap); end
   endtask

   task automatic test_mapram();
      runFetch(16'h1FFF);
      outPort(16'h00E3, 8'h40);
      checks++; if (bus.divRam !== 1'b1) begin errors++; $display("FAIL mapram_set: got %0b expected 1", bus.divRam); end
      checks++; if (bus.divMap !== 1'b0) begin errors++; $display("FAIL mapram_map: got %0b expected 0", bus.divMap); end
      outPort(16'h00E3, 8'h00);
      checks++; if (bus.divRam !== 1'b1) begin errors++; $display("FAIL mapram_locked: got %0b expected 1", bus.divRam); end
      outPort(16'h00E3, 8'h80);
      checks++; if (bus.divRam !== 1'b0) begin errors++; $display("FAIL conmem_forces_rom: got %0b expected 0", bus.divRam); end
      checks++; if (bus.divMap !== 1'b1) begin errors++; $display("FAIL conmem_map: got %0b expected 1", bus.divMap); end
      runFetch(16'h3D00);
      runFetch(16'h1FF9);
      checks++; if (bus.divMap !== 1'b1) begin errors++; $display("FAIL unmap_keeps_conmem: got %0b expected 1", bus.divMap); end
      outPort(16'h00E3, 8'h0A);
      checks++; if (bus.divMap !== expMap()) begin errors++; $display("FAIL conmem_clear_map: got %0b expected %0b", bus.divMap, expMap()); end
      checks++; if (bus.divRam !== 1'b1) begin errors++; $display("FAIL mapram_back: got %0b expected 1", bus.divRam); end
      checks++; if (bus.divPage !== 4'hA) begin errors++; $display("FAIL bank_a: got %0h expected a", bus.divPage); end
   endtask

   task automatic test_reset_pending();
      runFetch(16'h1FF8);
      outPort(16'h00E3, 8'h03);
      fetchStart(16'h0000);
      #2 reset = 0;
      #1;
      checks++; if (bus.divRam !== 1'b0) begin errors++; $display("FAIL reset_async_ram: got %0b expected 0", bus.divRam); end
      checks++; if (bus.divPage !== 4'd0) begin errors++; $display("FAIL reset_async_page: got %0h expected 0", bus.divPage); end
      busIdle();
      repeat (2) @(negedge clock);
      reset = 1;
      modelReset();
      repeat (3) @(negedge clock);
      checks++; if (bus.divMap !== 1'b0) begin errors++; $display("FAIL reset_discards_pending: got %0b expected 0", bus.divMap); end
   endtask

   task automatic test_intack();
      @(negedge clock);
      bus.a = 16'h0038; bus.m1 = 0; bus.iorq = 0;
      repeat (2) @(negedge clock);
      checks++; if (bus.divMap !== 1'b0) begin errors++; $display("FAIL intack_during: got %0b expected 0", bus.divMap); end
      busIdle();
      repeat (3) @(negedge clock);
      checks++; if (bus.divMap !== 1'b0) begin errors++; $display("FAIL intack_no_map: got %0b expected 0", bus.divMap); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 200; n++) begin
         int unsigned op;
         logic [15:0] addr;
         logic [7:0]  data;
         op = $urandom_range(0, 4);
         addr = pickAddr();
         case (op)
            0: begin
               data = 8'($urandom);
               addr = {8'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hE3};
               outPort(addr, data);
            end
            1: begin
               fetchStart(addr);
               checks++; if (bus.divMap !== (expMap() | (addr[15:8] == 8'h3D))) begin errors++; $display("FAIL rnd_fetch_map @%h: got %0b expected %0b", addr, bus.divMap, expMap() | (addr[15:8] == 8'h3D)); end
               fetchEnd();
               @(posedge clock); #1;
               modelFetch(addr);
            end
            2: begin
               @(negedge clock);
               bus.a = addr; bus.m1 = 0; bus.iorq = 0;
               repeat (2) @(negedge clock);
               busIdle();
               @(posedge clock); #1;
            end
            3: begin
               @(negedge clock);
               bus.a = {8'($urandom), 8'hE3}; bus.iorq = 0; bus.rd = 0;
               repeat (2) @(negedge clock);
               busIdle();
               @(posedge clock); #1;
            end
            default: begin
               @(negedge clock);
               bus.a = addr; bus.mreq = 0; bus.rd = 0;
               repeat (2) @(negedge clock);
               checks++; if (bus.divMap !== expMap()) begin errors++; $display("FAIL rnd_memrd_map @%h: got %0b expected %0b", addr, bus.divMap, expMap()); end
               busIdle();
               @(posedge clock); #1;
            end
         endcase
         checks++; if (bus.divMap !== expMap()) begin errors++; $display("FAIL rnd_map op%0d @%h: got %0b expected %0b", op, addr, bus.divMap, expMap()); end
         checks++; if (bus.divRam !== expRam()) begin errors++; $display("FAIL rnd_ram op%0d: got %0b expected %0b", op, bus.divRam, expRam()); end
         checks++; if (bus.divPage !== mBank) begin errors++; $display("FAIL rnd_page op%0d: got %0h expected %0h", op, bus.divPage, mBank); end
      end
   endtask

`ifdef DIV_NMI_EN
   task automatic test_nmi();
      bit seen;
      runFetch(16'h1FF8);
      outPort(16'h00E3, 8'h00);
      checks++; if (nmi !== 1'b1) begin errors++; $display("FAIL nmi_idle: got %0b expected 1", nmi); end
      @(negedge clock);
      nmiButton = 1;
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1;
         if (nmi === 1'b0) begin
            seen = 1;
            break;
         end
      end
      checks++; if (!seen) begin errors++; $display("FAIL nmi_assert: got %0b expected 0 within 3 clocks", nmi); end
      repeat (3) @(negedge clock);
      nmiButton = 0;
      repeat (3) @(negedge clock);
      checks++; if (nmi !== 1'b0) begin errors++; $display("FAIL nmi_held: got %0b expected 0", nmi); end
      runFetch(16'h0038);
      checks++; if (nmi !== 1'b0) begin errors++; $display("FAIL nmi_other_entry: got %0b expected 0", nmi); end
      runFetch(16'h1FF8);
      fetchStart(16'h0066);
      checks++; if (nmi !== 1'b0) begin errors++; $display("FAIL nmi_during_fetch: got %0b expected 0", nmi); end
      fetchEnd();
      @(posedge clock); #1;
      modelFetch(16'h0066);
      checks++; if (nmi !== 1'b1) begin errors++; $display("FAIL nmi_cleared: got %0b expected 1", nmi); end
      checks++; if (bus.divMap !== 1'b1) begin errors++; $display("FAIL nmi_map: got %0b expected 1", bus.divMap); end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_port();
      test_automap();
      test_instant();
      test_mapram();
      test_reset_pending();
      test_intack();
      test_random();
`ifdef DIV_NMI_EN
      test_nmi();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
